// File: rtl/tx_stream_arbiter.sv
// tx_stream_arbiter: packet-level round-robin arbiter sharing one Avalon-ST transmit path between NUM_SRC streams.
module tx_stream_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int EMPTY_WIDTH = 2,
  parameter int NUM_SRC     = 2,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_SRC-1:0]             src_enable,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]  in_data,
  input  logic [NUM_SRC-1:0]             in_valid,
  input  logic [NUM_SRC-1:0]             in_sop,
  input  logic [NUM_SRC-1:0]             in_eop,
  input  logic [NUM_SRC*EMPTY_WIDTH-1:0] in_empty,
  output logic [NUM_SRC-1:0]             in_ready,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic                           out_valid,
  output logic                           out_sop,
  output logic                           out_eop,
  output logic [EMPTY_WIDTH-1:0]         out_empty,
  input  logic                           out_ready,
  output logic                           grant_busy,
  output logic [$clog2(NUM_SRC)-1:0]     grant_idx,
  output logic [NUM_SRC*COUNT_WIDTH-1:0] pkt_count,
  output logic [COUNT_WIDTH-1:0]         drop_count
);
  localparam int IW = $clog2(NUM_SRC);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [NUM_SRC-1:0] cand, orphan;
  logic [IW-1:0] last_grant, win_idx, j;
  logic win_found, busy, xfer;
  assign busy = state == BUSY;
  assign grant_busy = busy;
  assign cand = in_valid & in_sop & src_enable;
  // Mid-packet beats seen while idle have no owner and are drained.
  assign orphan = busy ? '0 : in_valid & ~in_sop & src_enable;
  assign out_valid = busy & in_valid[grant_idx];
  assign out_sop = busy & in_sop[grant_idx];
  assign out_eop = busy & in_eop[grant_idx];
  assign out_data = in_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
  assign out_empty = in_empty[grant_idx*EMPTY_WIDTH +: EMPTY_WIDTH];
  assign xfer = out_valid & out_ready;
  assign in_ready = busy ? NUM_SRC'(out_ready) << grant_idx : orphan;
  // Scan farthest-first so the nearest candidate after last_grant wins.
  always_comb begin
    win_found = 1'b0;
    win_idx = '0;
    j = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      j = IW'((int'(last_grant) + k) % NUM_SRC);
      if (cand[j]) begin
        win_found = 1'b1;
        win_idx = j;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant_idx <= '0;
      last_grant <= IW'(NUM_SRC - 1);
      pkt_count <= '0;
      drop_count <= '0;
    end else begin
      drop_count <= drop_count + COUNT_WIDTH'($countones(orphan));
      if (!busy && win_found) begin
        state <= BUSY;
        grant_idx <= win_idx;
      end else if (xfer && out_eop) begin
        state <= IDLE;
        last_grant <= grant_idx;
        pkt_count[grant_idx*COUNT_WIDTH +: COUNT_WIDTH] <= pkt_count[grant_idx*COUNT_WIDTH +: COUNT_WIDTH] + COUNT_WIDTH'(1);
      end
    end
  end
endmodule
